// File: rtl/dmem_ctrl.sv
// Byte-addressable RV32I data memory. Responses come READ_LAT cycles after a load and one cycle after a store or fault.
// One request in flight: req_ready stays low until the response is taken, and the response is held while rsp_ready is low.
module dmem_ctrl #(
  parameter int unsigned DEPTH_BYTES    = 8192,
  parameter int unsigned READ_LAT       = 1,
  parameter bit          MISALIGN_FAULT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_ctrl,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_err
);

  localparam int unsigned AW = $clog2(DEPTH_BYTES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LWAIT = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  err_q, err_d;

  logic [7:0]  mem_q [DEPTH_BYTES];

  logic        accept;
  logic [2:0]  nbytes;
  logic        illegal;
  logic        misal;
  logic        oor;
  logic [32:0] last_addr;
  logic [1:0]  err_acc;
  logic [AW-1:0] idx [4];
  logic [7:0]  byte_rd [4];
  logic [31:0] load_val;

  assign req_ready = (state_q == IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  always_comb begin
    nbytes  = 3'd1;
    illegal = 1'b0;
    case (req_ctrl)
      3'b000, 3'b100: nbytes = 3'd1;
      3'b001, 3'b101: nbytes = 3'd2;
      3'b010:         nbytes = 3'd4;
      default:        illegal = 1'b1;
    endcase
    // Unsigned sizes only make sense for loads.
    if (req_we && req_ctrl[2]) illegal = 1'b1;

    misal = MISALIGN_FAULT &&
            (((nbytes == 3'd2) && req_addr[0]) ||
             ((nbytes == 3'd4) && (req_addr[1:0] != 2'b00)));

    // 33-bit end address so accesses near 2^32 cannot wrap back into range.
    last_addr = {1'b0, req_addr} + {30'b0, nbytes} - 33'd1;
    oor       = last_addr >= 33'(DEPTH_BYTES);

    if (illegal)    err_acc = 2'b11;
    else if (misal) err_acc = 2'b01;
    else if (oor)   err_acc = 2'b10;
    else            err_acc = 2'b00;
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      idx[k]     = req_addr[AW-1:0] + AW'(k);
      byte_rd[k] = mem_q[idx[k]];
    end
  end

  always_comb begin
    load_val = 32'd0;
    case (req_ctrl)
      3'b000:  load_val = {{24{byte_rd[0][7]}}, byte_rd[0]};
      3'b100:  load_val = {24'd0, byte_rd[0]};
      3'b001:  load_val = {{16{byte_rd[1][7]}}, byte_rd[1], byte_rd[0]};
      3'b101:  load_val = {16'd0, byte_rd[1], byte_rd[0]};
      3'b010:  load_val = {byte_rd[3], byte_rd[2], byte_rd[1], byte_rd[0]};
      default: load_val = 32'd0;
    endcase
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (accept && req_we && (err_acc == 2'b00)) begin
      for (int k = 0; k < 4; k++) begin
        if (k < int'(nbytes)) mem_q[idx[k]] <= req_wdata[8*k +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          err_d   = err_acc;
          rdata_d = (req_we || (err_acc != 2'b00)) ? 32'd0 : load_val;
          cnt_d   = 3'd0;
          if (!req_we && (err_acc == 2'b00) && (READ_LAT > 1)) begin
            state_d = LWAIT;
            cnt_d   = 3'd1;
          end else begin
            state_d = RESP;
          end
        end
      end
      LWAIT: begin
        // cnt_q counts completed wait cycles; leaving after READ_LAT-1 of them.
        if (cnt_q >= 3'(READ_LAT - 1)) begin
          state_d = RESP;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
          rdata_d = 32'd0;
          err_d   = 2'b00;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      rdata_q <= 32'd0;
      err_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: two instances (slow/strict and fast/permissive) against a byte-array reference.
module tb_dmem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [2:0]  req_ctrl  [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic [1:0]  rsp_err   [2];

  dmem_ctrl #(.DEPTH_BYTES(8192), .READ_LAT(3), .MISALIGN_FAULT(1'b1)) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_ctrl(req_ctrl[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  dmem_ctrl #(.DEPTH_BYTES(256), .READ_LAT(1), .MISALIGN_FAULT(1'b0)) u_dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_ctrl(req_ctrl[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] mdl [2][8192];

  function automatic int depth_of(input int u); return (u == 0) ? 8192 : 256; endfunction
  function automatic int rl_of(input int u);    return (u == 0) ? 3 : 1;      endfunction
  function automatic bit mf_of(input int u);    return (u == 0);              endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference behaviour of one transaction; updates the byte model on legal stores.
  task automatic model(input int u, input bit we, input bit [2:0] ctrl, input bit [31:0] addr,
                       input bit [31:0] wd, output bit [31:0] rd, output bit [1:0] er, output int lat);
    int nb;
    longint last;
    bit [63:0] v;
    nb   = (ctrl[1:0] == 2'd0) ? 1 : (ctrl[1:0] == 2'd1) ? 2 : 4;
    last = {32'd0, addr};
    last = last + nb - 1;
    rd   = 32'd0;
    lat  = 1;
    if (ctrl == 3'd3 || ctrl == 3'd6 || ctrl == 3'd7 || (we && ctrl >= 3'd4)) er = 2'b11;
    else if (mf_of(u) && (addr % nb) != 0) er = 2'b01;
    else if (last >= depth_of(u)) er = 2'b10;
    else begin
      er = 2'b00;
      if (we) begin
        for (int k = 0; k < nb; k++) mdl[u][int'(addr) + k] = 8'((wd >> (8 * k)) & 32'hFF);
      end else begin
        v = 64'd0;
        for (int k = 0; k < nb; k++) v = v | (64'(mdl[u][int'(addr) + k]) << (8 * k));
        if (ctrl < 3'd4 && nb < 4 && v[8 * nb - 1]) v = v - (64'd1 << (8 * nb));
        rd  = v[31:0];
        lat = rl_of(u);
      end
    end
  endtask

  // Called at a negedge; returns at a negedge with the handshake complete.
  task automatic do_req(input int u, input bit we, input bit [2:0] ctrl, input bit [31:0] addr,
                        input bit [31:0] wd, input int hold,
                        output logic [31:0] rd, output logic [1:0] er);
    bit [31:0] erd;
    bit [1:0]  eer;
    int        elat;
    int        waitc;
    int        lat;
    rd = 32'hx;
    er = 2'bx;
    waitc = 0;
    while (!req_ready[u] && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    if (!req_ready[u]) begin
      check("req_ready_timeout", 32'(req_ready[u]), 32'd1);
      return;
    end
    model(u, we, ctrl, addr, wd, erd, eer, elat);
    req_valid[u] = 1'b1;
    req_we[u]    = we;
    req_ctrl[u]  = ctrl;
    req_addr[u]  = addr;
    req_wdata[u] = wd;
    @(negedge clk);
    req_valid[u] = 1'b0;
    lat = 1;
    while (!rsp_valid[u] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(elat));
    rd = rsp_rdata[u];
    er = rsp_err[u];
    check("rdata", rd, erd);
    check("err", 32'(er), 32'(eer));
    for (int h = 0; h < hold; h++) begin
      // A competing store that must be ignored while the response is pending.
      req_valid[u] = 1'b1;
      req_we[u]    = 1'b1;
      req_ctrl[u]  = 3'b010;
      req_addr[u]  = 32'h10;
      req_wdata[u] = 32'hBAD0BAD0;
      @(negedge clk);
      check("hold_valid", 32'(rsp_valid[u]), 32'd1);
      check("hold_rdata", rsp_rdata[u], erd);
      check("hold_err", 32'(rsp_err[u]), 32'(eer));
      check("hold_ready", 32'(req_ready[u]), 32'd0);
    end
    req_valid[u] = 1'b0;
    rsp_ready[u] = 1'b1;
    @(negedge clk);
    rsp_ready[u] = 1'b0;
    check("post_rsp_valid", 32'(rsp_valid[u]), 32'd0);
    check("post_req_ready", 32'(req_ready[u]), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic [1:0]  er;
    int          u;
    int          r;
    bit          we;
    bit [2:0]    ctrl;
    bit [31:0]   addr;
    bit [2:0]    legal_ctrl [5];
    legal_ctrl = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_we[i] = 1'b0; req_ctrl[i] = 3'b0;
      req_addr[i] = 32'd0; req_wdata[i] = 32'd0; rsp_ready[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(req_ready[0]), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    check("rst_rdata", rsp_rdata[0], 32'd0);
    check("rst_err", 32'(rsp_err[0]), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rel_req_ready0", 32'(req_ready[0]), 32'd1);
    check("rel_req_ready1", 32'(req_ready[1]), 32'd1);

    for (int uu = 0; uu < 2; uu++) begin
      for (int a = 0; a < 72; a += 4) do_req(uu, 1'b1, 3'b010, 32'(a), $urandom, 0, rd, er);
      for (int a = depth_of(uu) - 8; a < depth_of(uu); a += 4)
        do_req(uu, 1'b1, 3'b010, 32'(a), $urandom, 0, rd, er);
    end

    do_req(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, rd, er);
    check("sw_ok", 32'(er), 32'd0);
    do_req(0, 1'b0, 3'b010, 32'h10, 32'd0, 0, rd, er);
    check("lw_deadbeef", rd, 32'hDEADBEEF);
    do_req(0, 1'b0, 3'b000, 32'h10, 32'd0, 0, rd, er);
    check("lb", rd, 32'hFFFFFFEF);
    do_req(0, 1'b0, 3'b100, 32'h13, 32'd0, 0, rd, er);
    check("lbu", rd, 32'h000000DE);
    do_req(0, 1'b0, 3'b001, 32'h12, 32'd0, 0, rd, er);
    check("lh", rd, 32'hFFFFDEAD);
    do_req(0, 1'b0, 3'b101, 32'h10, 32'd0, 0, rd, er);
    check("lhu", rd, 32'h0000BEEF);

    do_req(0, 1'b1, 3'b010, 32'h20, 32'hCAFEF00D, 0, rd, er);
    do_req(0, 1'b1, 3'b001, 32'h21, 32'h1234, 0, rd, er);
    check("sh_misal", 32'(er), 32'd1);
    do_req(0, 1'b0, 3'b010, 32'h20, 32'd0, 0, rd, er);
    check("lw_untouched", rd, 32'hCAFEF00D);
    do_req(1, 1'b1, 3'b001, 32'h21, 32'h1234, 0, rd, er);
    check("sh_misal_ok", 32'(er), 32'd0);
    do_req(1, 1'b0, 3'b101, 32'h21, 32'd0, 0, rd, er);
    check("lhu_misal", rd, 32'h00001234);

    do_req(0, 1'b0, 3'b010, 32'(8192 - 4), 32'd0, 0, rd, er);
    check("lw_top_ok", 32'(er), 32'd0);
    do_req(0, 1'b0, 3'b010, 32'(8192 - 2), 32'd0, 0, rd, er);
    check("lw_top_misal", 32'(er), 32'd1);
    do_req(0, 1'b0, 3'b000, 32'd8192, 32'd0, 0, rd, er);
    check("lb_oor", 32'(er), 32'd2);
    do_req(0, 1'b0, 3'b010, 32'hFFFFFFFC, 32'd0, 0, rd, er);
    check("lw_wrap_oor", 32'(er), 32'd2);
    do_req(0, 1'b1, 3'b100, 32'h30, 32'h55, 0, rd, er);
    check("st_bu_illegal", 32'(er), 32'd3);
    do_req(0, 1'b0, 3'b111, 32'h30, 32'd0, 0, rd, er);
    check("ld_111_illegal", 32'(er), 32'd3);
    do_req(1, 1'b0, 3'b010, 32'd254, 32'd0, 0, rd, er);
    check("lw_straddle_oor", 32'(er), 32'd2);

    do_req(0, 1'b0, 3'b010, 32'h10, 32'd0, 5, rd, er);
    do_req(0, 1'b0, 3'b010, 32'h10, 32'd0, 0, rd, er);
    check("lw_after_ignored", rd, 32'hDEADBEEF);

    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_ctrl[0] = 3'b010; req_addr[0] = 32'h10;
    @(negedge clk);
    req_valid[0] = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(rsp_valid[0]), 32'd0);
    check("mid_rst_ready", 32'(req_ready[0]), 32'd0);
    check("mid_rst_rdata", rsp_rdata[0], 32'd0);
    check("mid_rst_err", 32'(rsp_err[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("after_rst_valid", 32'(rsp_valid[0]), 32'd0);
      check("after_rst_ready", 32'(req_ready[0]), 32'd1);
    end
    do_req(0, 1'b0, 3'b010, 32'h10, 32'd0, 0, rd, er);
    check("data_survives_rst", rd, 32'hDEADBEEF);

    for (int i = 0; i < 300; i++) begin
      u  = int'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) ctrl = 3'($urandom_range(0, 7));
      else ctrl = legal_ctrl[$urandom_range(0, 4)];
      r = int'($urandom_range(0, 9));
      if (r < 7)      addr = 32'($urandom_range(0, 63));
      else if (r < 9) addr = 32'(depth_of(u) - 8) + 32'($urandom_range(0, 15));
      else            addr = $urandom;
      do_req(u, we, ctrl, addr, $urandom, int'($urandom_range(0, 2)), rd, er);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
